comb_equiv_sweeper: RTL
=======================

// Module: comb_equiv_sweeper
// PURPOSE
// - Downstream checking stage for paired combinational models (continuous-assign vs always_comb).
// - Drives every input vector in turn onto both models under test and waits a settle window.
// - Compares the two result buses and accumulates a mismatch count.
// - Replaces the single hand-written "apply, #0, compare" initial block with a clocked,
//   exhaustive and repeatable sweep.
// PARAMETERS
// - N_IN    default 2   width of stim bus; the sweep covers 2**N_IN vectors (1..16).
// - W       default 1   width of each result bus under comparison.
// - SETTLE  default 1   idle cycles between applying stim and sampling results (0..15).
// - CNT_W   default 8   width of mismatch_cnt; the counter saturates.
// PORTS
// - clk             in   1      rising-edge clock.
// - rst             in   1      asynchronous reset, active-high.
// - start           in   1      1-cycle pulse; starts a sweep. Accepted only in IDLE or DONE.
// - stim            out  N_IN   input vector driven to both models under test.
// - res_ca          in   W      result from the continuous-assign model.
// - res_ac          in   W      result from the always_comb model.
// - busy            out  1      high while a sweep is running (APPLY/WAIT/CHECK).
// - done            out  1      high in DONE; held until the next start or rst.
// - pass            out  1      valid when done: 1 iff mismatch_cnt==0.
// - mismatch_cnt    out  CNT_W  number of vectors that mismatched (saturating).
// - first_bad_stim  out  N_IN   first mismatching vector (DIFF_LOG_EN only).
// - first_bad_valid out  1      first_bad_stim holds a captured vector (DIFF_LOG_EN only).
// BEHAVIOUR
// - Reset values: state=IDLE, stim=0, busy=0, done=0, pass=0, mismatch_cnt=0,
//   first_bad_stim=0, first_bad_valid=0. Reset asserted mid-sweep aborts immediately to these values.
// - FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
//   IDLE/DONE --start--> APPLY. Entry clears mismatch_cnt, first_bad_*, done and pass; vec=0.
//   APPLY (1 cycle): stim<=vec. Next state is WAIT if SETTLE>0, else CHECK.
//   WAIT (exactly SETTLE cycles, counted down) -> CHECK.
//   CHECK (1 cycle): sample and compare. If vec==2**N_IN-1 -> DONE, else vec<=vec+1 -> APPLY.
// - Per-vector cost is SETTLE+2 cycles. done rises (SETTLE+2)*2**N_IN cycles after the start edge.
// - Compare rule: a mismatch is res_ca !== res_ac (4-state case inequality).
//   Any X/Z bit that differs counts as a mismatch; identical X on both sides does not.
// - mismatch_cnt increments by 1 per mismatching vector and saturates at 2**CNT_W-1 (no wrap).
// - stim is held stable from APPLY through CHECK. After DONE it keeps the last vector (all ones).
// - start while busy is ignored. start in DONE restarts the sweep.
// - vec counter is N_IN+1 bits internally, so the last-vector compare never wraps.
// - pass is registered on entry to DONE; pass=0 outside DONE.
// CONFIGURATION
// - DIFF_LOG_EN defined: on the first mismatch of a sweep, latch vec into first_bad_stim and set
//   first_bad_valid=1. Later mismatches do not overwrite it. Both are cleared on start and rst.
// - DIFF_LOG_EN undefined: first_bad_stim tied to 0 and first_bad_valid tied to 0; no capture logic.
// TESTING
// - N_IN=2,W=1,SETTLE=1; both models a&b; start -> done at cycle 12, pass=1, mismatch_cnt=0.
// - res_ac = stim[1]|stim[0] (fault) -> mismatch_cnt=2, pass=0; with DIFF_LOG_EN first_bad_stim=2'b01.
// - res_ac forced 1'bx, res_ca=a&b -> mismatch_cnt=4. Both forced x -> mismatch_cnt=0.
// - CNT_W=1, N_IN=2, always-mismatch -> mismatch_cnt saturates at 1 and pass=0.
// - rst pulsed during WAIT of vector 2 -> all outputs at reset values on the same edge;
//   a new start gives a full clean sweep.
// - start pulsed while busy -> ignored, sweep timing unchanged. start in DONE -> counters cleared, resweep.

Source files
------------

// File: rtl/comb_equiv_sweeper.sv
// Exhaustive clocked equivalence sweep of two combinational models sharing one stimulus bus.
// Optional first-mismatch capture is enabled by defining DIFF_LOG_EN.
module comb_equiv_sweeper #(
  parameter int N_IN   = 2,
  parameter int W      = 1,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic [W-1:0]     res_ca,
  input  logic [W-1:0]     res_ac,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [N_IN-1:0]  first_bad_stim,
  output logic             first_bad_valid
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Extra vec bit keeps the last-vector compare from wrapping to zero.
  localparam logic [N_IN:0] LAST_VEC  = (N_IN+1)'((1 << N_IN) - 1);
  localparam logic [3:0]    WAIT_INIT = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t           r_state;
  state_t           w_next;
  logic [N_IN:0]    r_vec;
  logic [3:0]       r_waitCnt;
  logic [N_IN-1:0]  r_stim;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pass;
  logic             w_start;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_cntNext;

  assign w_start    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_mismatch = (res_ca !== res_ac);
  assign w_cntNext  = (w_mismatch && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_next = ST_APPLY;
      ST_APPLY:         w_next = (SETTLE > 0) ? ST_WAIT : ST_CHECK;
      ST_WAIT:          if (r_waitCnt == 4'd0) w_next = ST_CHECK;
      ST_CHECK:         w_next = (r_vec == LAST_VEC) ? ST_DONE : ST_APPLY;
      default:          w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec     <= '0;
      r_waitCnt <= '0;
      r_stim    <= '0;
      r_cnt     <= '0;
      r_pass    <= 1'b0;
    end else if (w_start) begin
      r_vec  <= '0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        ST_APPLY: begin
          r_stim    <= r_vec[N_IN-1:0];
          r_waitCnt <= WAIT_INIT;
        end
        ST_WAIT: begin
          if (r_waitCnt != 4'd0) r_waitCnt <= r_waitCnt - 4'd1;
        end
        ST_CHECK: begin
          r_cnt <= w_cntNext;
          if (r_vec == LAST_VEC) r_pass <= (w_cntNext == '0);
          else                   r_vec  <= r_vec + (N_IN+1)'(1);
        end
        default: ;
      endcase
    end
  end

  assign stim         = r_stim;
  assign mismatch_cnt = r_cnt;
  assign pass         = r_pass;
  assign busy         = (r_state == ST_APPLY) || (r_state == ST_WAIT) || (r_state == ST_CHECK);
  assign done         = (r_state == ST_DONE);

`ifdef DIFF_LOG_EN
  logic [N_IN-1:0] r_firstBadStim;
  logic            r_firstBadValid;

  // Only the first mismatch of a sweep is kept; later ones leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_firstBadStim  <= '0;
      r_firstBadValid <= 1'b0;
    end else if (w_start) begin
      r_firstBadStim  <= '0;
      r_firstBadValid <= 1'b0;
    end else if ((r_state == ST_CHECK) && w_mismatch && !r_firstBadValid) begin
      r_firstBadStim  <= r_vec[N_IN-1:0];
      r_firstBadValid <= 1'b1;
    end
  end

  assign first_bad_stim  = r_firstBadStim;
  assign first_bad_valid = r_firstBadValid;
`else
  assign first_bad_stim  = '0;
  assign first_bad_valid = 1'b0;
`endif

endmodule
